// File: rtl/mixed_add_pipe_pkg.sv
// Shared types and width/saturation helpers for the mixed-sign adder pipeline.
package mixed_add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Exact width of A(unsigned) +/- B(signed): one bit for A's sign, one for carry.
  function automatic int full_w(input int a_w, input int b_w);
    return ((a_w + 1 > b_w) ? a_w + 1 : b_w) + 1;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mixed_add_pipe_stage.sv
// Single ready/valid register slice; chained to form the adder pipeline.
module mixed_add_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid never depends on ready, ready may depend on the downstream ready.
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mixed_add_pipe.sv
// Pipelined unsigned A +/- signed B with stream handshake and overflow flag.
// Define MIXED_ADD_PIPE_SAT_EN to saturate on overflow instead of wrapping.
module mixed_add_pipe
  import mixed_add_pkg::*;
#(
  parameter int A_W   = 21,
  parameter int B_W   = 18,
  parameter int OUT_W = 23,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_c,
  output logic             out_ovf
);

  localparam int FULL_W = full_w(A_W, B_W);
  localparam int PW     = OUT_W + 1;

  op_e                      op;
  logic signed [FULL_W-1:0] a_ext, b_ext, sum;
  logic [OUT_W-1:0]         conv_c;
  logic                     conv_ovf;

  always_comb begin
    op    = op_e'(in_sub);
    a_ext = signed'({{(FULL_W - A_W){1'b0}}, in_a});
    b_ext = signed'({{(FULL_W - B_W){in_b[B_W-1]}}, in_b});
    sum   = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
  end

  if (OUT_W >= FULL_W) begin : g_wide
    always_comb begin
      conv_c   = OUT_W'(sum);
      conv_ovf = 1'b0;
    end
  end else begin : g_narrow
    // S fits OUT_W exactly when every bit from OUT_W-1 upward equals the sign.
    logic [FULL_W-OUT_W:0] top;
`ifdef MIXED_ADD_PIPE_SAT_EN
    localparam logic [63:0] SAT_HI = sat_max(OUT_W);
    localparam logic [63:0] SAT_LO = sat_min(OUT_W);
`endif
    always_comb begin
      top      = sum[FULL_W-1:OUT_W-1];
      conv_ovf = !((&top) || !(|top));
`ifdef MIXED_ADD_PIPE_SAT_EN
      if (conv_ovf) conv_c = sum[FULL_W-1] ? SAT_LO[OUT_W-1:0] : SAT_HI[OUT_W-1:0];
      else          conv_c = sum[OUT_W-1:0];
`else
      conv_c = sum[OUT_W-1:0];
`endif
    end
  end

  logic          v [PIPE+1];
  logic          r [PIPE+1];
  logic [PW-1:0] d [PIPE+1];

  assign v[0]    = in_valid;
  assign d[0]    = {conv_ovf, conv_c};
  assign r[PIPE] = out_ready;

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    mixed_add_stage #(.W(PW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v[k]),
      .in_ready  (r[k]),
      .in_data   (d[k]),
      .out_valid (v[k+1]),
      .out_ready (r[k+1]),
      .out_data  (d[k+1])
    );
  end

  // Flops clear under reset, so the ready chain alone would already read 1.
  assign in_ready  = r[0] && !rst;
  assign out_valid = v[PIPE];
  assign out_ovf   = d[PIPE][PW-1];
  assign out_c     = d[PIPE][OUT_W-1:0];

endmodule
